// File: rtl/g3f_period_monitor_pkg.sv
// Shared types and constants for the g3f period monitor.
// No logic here: state encoding, core widths and a one-hot helper.
package g3f_period_monitor_pkg;

    localparam int G3F_QW      = 3;
    localparam int G3F_NSTATES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [G3F_NSTATES-1:0] state_bit(input logic [G3F_QW-1:0] q);
        return {{(G3F_NSTATES-1){1'b0}}, 1'b1} << q;
    endfunction

endpackage

// File: rtl/g3f_step_detect.sv
// Turns the SE strobe into a step pulse aligned with the core's updated output.
// Latency: step is high one cycle after se was sampled high; no backpressure, frozen while ena=0.
// se_q holds while ena is low, so a resume does not see a stale edge.
module g3f_step_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic se,
    output logic step
);

    logic se_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            se_q <= 1'b0;
        end else if (ena) begin
            se_q <= se;
        end
    end

    assign step = se_q & ena;

endmodule

// File: rtl/g3f_period_monitor.sv
// Measures the step count for the g3f core to return to a captured start state.
// Latency: results and done valid the cycle after the returning step; no backpressure, frozen while ena=0.
// Results stay held in DONE until the next ARM capture; start is ignored in ARM/RUN.
module g3f_period_monitor
    import g3f_period_monitor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   se,
    input  logic [G3F_QW-1:0]      q_in,
    input  logic [G3F_QW-1:0]      p_in,
    input  logic                   start,
    output logic [CNT_W-1:0]       period,
    output logic [G3F_NSTATES-1:0] visited,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   p_mismatch
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                   step;
    state_t                 state, state_nxt;
    logic [G3F_QW-1:0]      ref_q, ref_q_nxt;
    logic [G3F_QW-1:0]      ref_p, ref_p_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0]       period_nxt;
    logic [G3F_NSTATES-1:0] visited_nxt;
    logic                   overflow_nxt;
    logic                   p_mismatch_nxt;

    g3f_step_detect u_step_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .se    (se),
        .step  (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ref_q      <= '0;
            ref_p      <= '0;
            cnt        <= '0;
            period     <= '0;
            visited    <= '0;
            overflow   <= 1'b0;
            p_mismatch <= 1'b0;
        end else if (ena) begin
            state      <= state_nxt;
            ref_q      <= ref_q_nxt;
            ref_p      <= ref_p_nxt;
            cnt        <= cnt_nxt;
            period     <= period_nxt;
            visited    <= visited_nxt;
            overflow   <= overflow_nxt;
            p_mismatch <= p_mismatch_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ref_q_nxt      = ref_q;
        ref_p_nxt      = ref_p;
        cnt_nxt        = cnt;
        cnt_inc        = cnt + CNT_ONE;
        period_nxt     = period;
        visited_nxt    = visited;
        overflow_nxt   = overflow;
        p_mismatch_nxt = p_mismatch;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (step) begin
                    ref_q_nxt      = q_in;
                    ref_p_nxt      = p_in;
                    visited_nxt    = state_bit(q_in);
                    cnt_nxt        = '0;
                    overflow_nxt   = 1'b0;
                    p_mismatch_nxt = 1'b0;
                    state_nxt      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step) begin
                    cnt_nxt     = cnt_inc;
                    visited_nxt = visited | state_bit(q_in);
                    // A return on the last countable step still counts as a clean return.
                    if (q_in == ref_q) begin
                        period_nxt     = cnt_inc;
                        p_mismatch_nxt = (p_in != ref_p);
                        state_nxt      = ST_DONE;
                    end else if (cnt_inc == CNT_MAX) begin
                        period_nxt   = CNT_MAX;
                        overflow_nxt = 1'b1;
                        state_nxt    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_ARM) || (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_g3f_period_monitor.sv
// Bench for g3f_period_monitor: behavioural core drives q_in/p_in, two widths checked side by side.
// Completed runs are scored against expectations queued when each run is armed.
module tb_g3f_period_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       se;
    logic [2:0] q_in;
    logic [2:0] p_in;
    logic       start;

    logic [7:0] period8, visited8;
    logic       busy8, done8, ovf8, pm8;
    logic [3:0] period4;
    logic [7:0] visited4;
    logic       busy4, done4, ovf4, pm4;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] q;
        logic [2:0] p;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        logic [7:0] period;
        logic [7:0] visited;
        logic       ovf;
        logic       pm;
    } res_t;

    vec_t tbl[8];
    res_t sb_q[$];

    always #5 clk = ~clk;

    g3f_period_monitor #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .se(se), .q_in(q_in), .p_in(p_in),
        .start(start), .period(period8), .visited(visited8), .busy(busy8),
        .done(done8), .overflow(ovf8), .p_mismatch(pm8)
    );

    g3f_period_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .se(se), .q_in(q_in), .p_in(p_in),
        .start(start), .period(period4), .visited(visited4), .busy(busy4),
        .done(done4), .overflow(ovf4), .p_mismatch(pm4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One core advance: SE high for a cycle, then the new state appears on q/p.
    task automatic do_step(input logic [2:0] q, input logic [2:0] p);
        @(negedge clk);
        se = 1'b1;
        @(negedge clk);
        se   = 1'b0;
        q_in = q;
        p_in = p;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] per, input logic [7:0] vis,
                            input logic ovf, input logic pm);
        res_t r;
        r.period  = per;
        r.visited = vis;
        r.ovf     = ovf;
        r.pm      = pm;
        sb_q.push_back(r);
    endtask

    task automatic score_done(input string name);
        res_t r;
        int   waited = 0;
        while (!done8 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!done8) begin
            check({name, "_timeout"}, 32'(done8), 32'd1);
        end else if (sb_q.size() == 0) begin
            check({name, "_unexpected"}, 32'(sb_q.size()), 32'd1);
        end else begin
            r = sb_q.pop_front();
            check({name, "_period"},  32'(period8),  32'(r.period));
            check({name, "_visited"}, 32'(visited8), 32'(r.visited));
            check({name, "_ovf"},     32'(ovf8),     32'(r.ovf));
            check({name, "_pm"},      32'(pm8),      32'(r.pm));
        end
    endtask

    task automatic run_table(input string name, input logic [2:0] last_p);
        for (int i = 0; i < 8; i++) begin
            do_step(tbl[i].q, (i == 7) ? last_p : tbl[i].p);
            check($sformatf("%s_busy%0d", name, i), 32'(busy8), 32'(tbl[i].busy));
            check($sformatf("%s_done%0d", name, i), 32'(done8), 32'(tbl[i].done));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Cycle 1,2,4,3,6,7,5 and back to 1: period 7, states 1..7 visited.
        tbl[0] = '{q: 3'd1, p: 3'b010, busy: 1'b1, done: 1'b0};
        tbl[1] = '{q: 3'd2, p: 3'b010, busy: 1'b1, done: 1'b0};
        tbl[2] = '{q: 3'd4, p: 3'b010, busy: 1'b1, done: 1'b0};
        tbl[3] = '{q: 3'd3, p: 3'b010, busy: 1'b1, done: 1'b0};
        tbl[4] = '{q: 3'd6, p: 3'b010, busy: 1'b1, done: 1'b0};
        tbl[5] = '{q: 3'd7, p: 3'b010, busy: 1'b1, done: 1'b0};
        tbl[6] = '{q: 3'd5, p: 3'b010, busy: 1'b1, done: 1'b0};
        tbl[7] = '{q: 3'd1, p: 3'b010, busy: 1'b0, done: 1'b1};

        rst_n = 1'b0; ena = 1'b1; se = 1'b0; start = 1'b0; q_in = 3'd0; p_in = 3'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_period",  32'(period8),  32'd0);
        check("rst_visited", 32'(visited8), 32'd0);
        check("rst_busy",    32'(busy8),    32'd0);
        check("rst_done",    32'(done8),    32'd0);
        check("rst_ovf",     32'(ovf8),     32'd0);
        check("rst_pm",      32'(pm8),      32'd0);
        rst_n = 1'b1;
        do_step(3'd2, 3'd1);
        do_step(3'd3, 3'd1);
        check("idle_busy", 32'(busy8), 32'd0);
        check("idle_done", 32'(done8), 32'd0);

        // Basic run; a step coinciding with start must not be captured
        @(negedge clk);
        se = 1'b1;
        @(negedge clk);
        se = 1'b0; start = 1'b1; q_in = 3'd4;
        @(negedge clk);
        start = 1'b0;
        check("arm_busy",    32'(busy8),    32'd1);
        check("arm_visited", 32'(visited8), 32'd0);
        push_exp(8'd7, 8'hFE, 1'b0, 1'b0);
        run_table("run1", 3'b010);
        score_done("run1");
        check("run1_w4_period", 32'(period4), 32'd7);
        check("run1_w4_ovf",    32'(ovf4),    32'd0);

        // Tag differs on the return step; done drops and period holds in ARM
        pulse_start();
        check("rearm_done",   32'(done8),   32'd0);
        check("rearm_period", 32'(period8), 32'd7);
        push_exp(8'd7, 8'hFE, 1'b0, 1'b1);
        run_table("run2", 3'b011);
        score_done("run2");

        // ena low mid-run with se toggling, then a stray start in RUN
        pulse_start();
        push_exp(8'd7, 8'hFE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_step(tbl[i].q, tbl[i].p);
        @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            se   = ~se;
            q_in = 3'd1;
            p_in = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        se = 1'b0;
        check("frz_busy",    32'(busy8),    32'd1);
        check("frz_visited", 32'(visited8), 32'h16);
        q_in = 3'd4; p_in = 3'b010;
        ena = 1'b1;
        pulse_start();
        check("stray_start_busy", 32'(busy8), 32'd1);
        for (int i = 3; i < 8; i++) do_step(tbl[i].q, tbl[i].p);
        score_done("run3");

        // Async reset in RUN, then re-arm from DONE
        pulse_start();
        do_step(3'd5, 3'd0);
        do_step(3'd6, 3'd0);
        check("pre_rst_busy", 32'(busy8), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",    32'(busy8),    32'd0);
        check("arst_visited", 32'(visited8), 32'd0);
        check("arst_period",  32'(period8),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        push_exp(8'd2, 8'h60, 1'b0, 1'b0);
        do_step(3'd5, 3'd1);
        do_step(3'd6, 3'd1);
        do_step(3'd5, 3'd1);
        score_done("run4");
        pulse_start();
        check("rearm2_busy",   32'(busy8),    32'd1);
        check("rearm2_done",   32'(done8),    32'd0);
        check("rearm2_period", 32'(period8),  32'd2);
        check("rearm2_vis",    32'(visited8), 32'h60);
        do_step(3'd3, 3'd0);
        check("cap_period",  32'(period8),  32'd2);
        check("cap_visited", 32'(visited8), 32'h08);

        // Overflow on the narrow instance: 15 steps never returning to 0
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        do_step(3'd0, 3'd0);
        for (int i = 0; i < 15; i++) begin
            do_step(3'((i % 7) + 1), 3'd0);
            if (i == 13) check("ovf_w4_busy14", 32'(busy4), 32'd1);
        end
        check("ovf_w4_done",    32'(done4),    32'd1);
        check("ovf_w4_ovf",     32'(ovf4),     32'd1);
        check("ovf_w4_period",  32'(period4),  32'hF);
        check("ovf_w4_visited", 32'(visited4), 32'hFF);
        check("ovf_w4_pm",      32'(pm4),      32'd0);
        check("ovf_w8_busy",    32'(busy8),    32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
